// File: rtl/bitblade_pkg.sv
// Shared definitions for the BitBlade serial MAC: precision codes, FSM states,
// and the slice-count helper.
package bitblade_pkg;

    localparam logic [1:0] PREC_2 = 2'b00;
    localparam logic [1:0] PREC_4 = 2'b01;
    localparam logic [1:0] PREC_8 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Code 2'b11 is reserved and treated as 8-bit.
    function automatic int unsigned slices_of(input logic [1:0] prec);
        case (prec)
            PREC_2:  return 1;
            PREC_4:  return 2;
            default: return 4;
        endcase
    endfunction

endpackage

// File: rtl/bitblade_slice_mul.sv
// 2b x 2b slice multiplier with per-operand sign flags, built as a 3x3
// Baugh-Wooley array over sign-extended slices; 6-bit signed product.
module bitblade_slice_mul (
    input  logic              i_a,
    input  logic [1:0]        i_a_sl,
    input  logic              i_b,
    input  logic [1:0]        i_b_sl,
    output logic signed [5:0] o_p
);
    logic [2:0]      w_a3;
    logic [2:0]      w_b3;
    logic [5:0]      w_sum;
    logic [2:0][2:0] w_pp;

    assign w_a3 = {i_a_sl[1] & i_a, i_a_sl};
    assign w_b3 = {i_b_sl[1] & i_b, i_b_sl};

    // Partial products touching exactly one sign bit are inverted; the
    // constant 40 (2^5 + 2^3) completes the Baugh-Wooley correction.
    always_comb begin
        w_sum = 6'd40;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_pp[i][j] = ((i == 2) != (j == 2)) ? ~(w_a3[i] & w_b3[j])
                                                    :  (w_a3[i] & w_b3[j]);
                w_sum = w_sum + ({5'b0, w_pp[i][j]} << (i + j));
            end
        end
    end

    assign o_p = $signed(w_sum);

endmodule

// File: rtl/bitblade_serial_mac.sv
// Precision-reconfigurable serial MAC: one 2b x 2b slice product per cycle.
// Define BITBLADE_MAC_SAT_EN for saturating accumulation with a sticky sat_flag.
module bitblade_serial_mac
    import bitblade_pkg::*;
#(
    parameter int MAX_BITS = 8,
    parameter int ACC_W    = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MAX_BITS-1:0] act,
    input  logic [MAX_BITS-1:0] wgt,
    input  logic [1:0]          prec,
    input  logic                sign_i,
    input  logic                sign_w,
    input  logic                acc_clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    result,
    output logic                sat_flag
);
    localparam int SMAX = MAX_BITS / 2;
    localparam int CW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int SW   = ACC_W + 2;
    localparam logic signed [SW-1:0] ACC_MAX = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = {3'b111, {(ACC_W-1){1'b0}}};
`ifdef BITBLADE_MAC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_t                   r_state;
    logic [MAX_BITS-1:0]      r_act, r_wgt;
    logic [CW-1:0]            r_i, r_j, r_last;
    logic                     r_sgn_i, r_sgn_w;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_sat;

    int unsigned              w_s;
    logic [CW-1:0]            w_last;
    logic [1:0]               w_a_sl, w_b_sl;
    logic signed [5:0]        w_pp;
    logic [CW:0]              w_ij;
    logic signed [SW-1:0]     w_term, w_sum;
    logic                     w_hi, w_lo, w_clamp;
    logic [ACC_W-1:0]         w_next;

    always_comb begin
        w_s = slices_of(prec);
        if (w_s > SMAX) w_s = SMAX;
        w_last = CW'(w_s - 1);
    end

    assign w_a_sl = r_act[{r_i, 1'b0} +: 2];
    assign w_b_sl = r_wgt[{r_j, 1'b0} +: 2];

    // Only the most significant slice of a signed operand carries the sign.
    bitblade_slice_mul u_mul (
        .i_a    (r_sgn_i && (r_i == r_last)),
        .i_a_sl (w_a_sl),
        .i_b    (r_sgn_w && (r_j == r_last)),
        .i_b_sl (w_b_sl),
        .o_p    (w_pp)
    );

    // Two guard bits keep the shifted term and the sum exact for clamping.
    assign w_ij    = {1'b0, r_i} + {1'b0, r_j};
    assign w_term  = SW'(w_pp) <<< {w_ij, 1'b0};
    assign w_sum   = SW'(r_acc) + w_term;
    assign w_hi    = w_sum > ACC_MAX;
    assign w_lo    = w_sum < ACC_MIN;
    assign w_clamp = SAT_EN && (w_hi || w_lo);
    assign w_next  = !w_clamp ? w_sum[ACC_W-1:0] :
                     w_hi     ? ACC_MAX[ACC_W-1:0] : ACC_MIN[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_act   <= '0;
            r_wgt   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_last  <= '0;
            r_sgn_i <= 1'b0;
            r_sgn_w <= 1'b0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_act   <= act;
                    r_wgt   <= wgt;
                    r_last  <= w_last;
                    r_sgn_i <= sign_i;
                    r_sgn_w <= sign_w;
                    r_i     <= '0;
                    r_j     <= '0;
                    if (acc_clr) begin
                        r_acc <= '0;
                        r_sat <= 1'b0;
                    end
                    r_state <= CALC;
                end
                CALC: begin
                    r_acc <= w_next;
                    if (w_clamp) r_sat <= 1'b1;
                    if (r_i == r_last) begin
                        r_i <= '0;
                        if (r_j == r_last) begin
                            r_j     <= '0;
                            r_state <= DONE;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_acc;
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_bitblade_serial_mac.sv
// Self-checking bench: directed table, backpressure/reset/ACC_W=16 sequences,
// and randomized ops against an integer-arithmetic reference model.
module tb_bitblade_serial_mac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        sign_i = 1'b0, sign_w = 1'b0, acc_clr = 1'b0;
    logic [7:0]  act = '0, wgt = '0;
    logic [1:0]  prec = '0;
    logic        in_ready_a, out_valid_a, sat_a;
    logic [23:0] res_a;
    logic        in_ready_b, out_valid_b, sat_b;
    logic [15:0] res_b;

    int     n_chk = 0;
    int     n_err = 0;
    longint acc_m = 0;

    always #5 clk = ~clk;

    bitblade_serial_mac #(.MAX_BITS(8), .ACC_W(24)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .act(act), .wgt(wgt), .prec(prec), .sign_i(sign_i), .sign_w(sign_w),
        .acc_clr(acc_clr), .out_valid(out_valid_a), .out_ready(out_ready),
        .result(res_a), .sat_flag(sat_a)
    );

    bitblade_serial_mac #(.MAX_BITS(8), .ACC_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .act(act), .wgt(wgt), .prec(prec), .sign_i(sign_i), .sign_w(sign_w),
        .acc_clr(acc_clr), .out_valid(out_valid_b), .out_ready(out_ready),
        .result(res_b), .sat_flag(sat_b)
    );

    typedef struct {
        logic [7:0] a, w;
        logic [1:0] p;
        logic       si, sw, clr;
        longint     exp;
    } vec_t;
    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic longint operand(input logic [7:0] x, input int b, input logic sg);
        longint v;
        v = longint'(x) & ((longint'(1) << b) - 1);
        if (sg && v >= (longint'(1) << (b - 1))) v -= (longint'(1) << b);
        return v;
    endfunction

    function automatic int bits_of(input logic [1:0] p);
        return (p == 2'b00) ? 2 : (p == 2'b01) ? 4 : 8;
    endfunction

    function automatic longint fit(input longint v, input int w);
        longint lim, m;
        lim = longint'(1) << (w - 1);
`ifdef BITBLADE_MAC_SAT_EN
        if (v >= lim) return lim - 1;
        if (v < -lim) return -lim;
        return v;
`else
        m = v & ((longint'(1) << w) - 1);
        if (m >= lim) m -= (longint'(1) << w);
        return m;
`endif
    endfunction

    // One full transaction on both instances in lockstep; checks the 24-bit one.
    task automatic do_op(input logic [7:0] a, input logic [7:0] w, input logic [1:0] p,
                         input logic si, input logic sw, input logic clr,
                         output longint r24);
        int k, b, busy_rdy;
        b = bits_of(p);
        act = a; wgt = w; prec = p; sign_i = si; sign_w = sw; acc_clr = clr;
        in_valid = 1'b1;
        chk("in_ready_idle", longint'(in_ready_a), 1);
        tick();
        in_valid = 1'b0;
        act = 8'($urandom); wgt = 8'($urandom); prec = 2'($urandom);
        k = 0; busy_rdy = 0;
        while (!out_valid_a && k < 40) begin
            if (in_ready_a) busy_rdy++;
            tick();
            k++;
        end
        chk("latency", k, (b / 2) * (b / 2));
        chk("in_ready_busy", busy_rdy, 0);
        if (clr) acc_m = 0;
        acc_m = fit(acc_m + operand(a, b, si) * operand(w, b, sw), 24);
        r24 = longint'($signed(res_a));
        chk("result_model", r24, acc_m);
        chk("sat_flag24", longint'(sat_a), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", longint'(out_valid_a), 0);
        chk("in_ready_after", longint'(in_ready_a), 1);
    endtask

    initial begin
        longint r;
        int k;

        tbl[0] = '{8'h03, 8'h02, 2'b00, 1'b1, 1'b1, 1'b1, 2};
        tbl[1] = '{8'hFF, 8'hFF, 2'b10, 1'b0, 1'b0, 1'b1, 65025};
        tbl[2] = '{8'h80, 8'h7F, 2'b10, 1'b1, 1'b1, 1'b1, -16256};
        tbl[3] = '{8'h03, 8'h04, 2'b10, 1'b1, 1'b1, 1'b0, -16244};
        tbl[4] = '{8'hF7, 8'hAC, 2'b01, 1'b1, 1'b1, 1'b1, -28};
        tbl[5] = '{8'hFE, 8'h05, 2'b11, 1'b1, 1'b0, 1'b1, -10};
        tbl[6] = '{8'h0F, 8'h08, 2'b01, 1'b0, 1'b1, 1'b0, -130};
        tbl[7] = '{8'h03, 8'h03, 2'b00, 1'b0, 1'b0, 1'b1, 9};

        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", longint'(in_ready_a), 1);
        chk("rst_out_valid", longint'(out_valid_a), 0);
        chk("rst_result", longint'(res_a), 0);
        chk("rst_sat", longint'(sat_a), 0);
        chk("rst_result16", longint'(res_b), 0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            do_op(tbl[v].a, tbl[v].w, tbl[v].p, tbl[v].si, tbl[v].sw, tbl[v].clr, r);
            chk($sformatf("table%0d", v), r, tbl[v].exp);
        end

        // Backpressure in DONE: held output, new requests ignored.
        act = 8'd5; wgt = 8'd6; prec = 2'b10; sign_i = 1'b0; sign_w = 1'b0;
        acc_clr = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid_a && k < 40) begin tick(); k++; end
        chk("bp_latency", k, 16);
        act = 8'd99; wgt = 8'd77; acc_clr = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_valid", longint'(out_valid_a), 1);
            chk("bp_result", longint'($signed(res_a)), 30);
            chk("bp_in_ready", longint'(in_ready_a), 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_ready", longint'(in_ready_a), 1);
        chk("bp_release_valid", longint'(out_valid_a), 0);
        chk("bp_idle_result", longint'($signed(res_a)), 30);
        acc_m = 30;

        // Three 127*127 signed ops; the 16-bit instance overflows on the third.
        do_op(8'd127, 8'd127, 2'b10, 1'b1, 1'b1, 1'b1, r);
        do_op(8'd127, 8'd127, 2'b10, 1'b1, 1'b1, 1'b0, r);
        chk("acc16_op2", longint'($signed(res_b)), 32258);
        chk("acc16_op2_sat", longint'(sat_b), 0);
        chk("acc24_op2", r, 32258);
        act = 8'd127; wgt = 8'd127; prec = 2'b10; sign_i = 1'b1; sign_w = 1'b1;
        acc_clr = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid_b && k < 40) begin tick(); k++; end
`ifdef BITBLADE_MAC_SAT_EN
        chk("acc16_op3", longint'($signed(res_b)), 32767);
        chk("acc16_op3_sat", longint'(sat_b), 1);
`else
        chk("acc16_op3", longint'($signed(res_b)), -17149);
        chk("acc16_op3_sat", longint'(sat_b), 0);
`endif
        chk("acc24_op3", longint'($signed(res_a)), 48387);
        acc_m = 48387;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        do_op(8'd1, 8'd1, 2'b00, 1'b0, 1'b0, 1'b1, r);
        chk("acc16_clr_sat", longint'(sat_b), 0);
        chk("acc16_clr_result", longint'($signed(res_b)), 1);

        for (int n = 0; n < 40; n++) begin
            do_op(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0), r);
        end

        // Reset at CALC cycle 7 of an 8-bit op.
        act = 8'd200; wgt = 8'd100; prec = 2'b10; sign_i = 1'b0; sign_w = 1'b0;
        acc_clr = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", longint'(out_valid_a), 0);
        chk("mid_rst_result", longint'(res_a), 0);
        #3 rst_n = 1'b1;
        acc_m = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid_a) break;
        end
        chk("post_rst_ready", longint'(in_ready_a), 1);
        chk("post_rst_valid", longint'(out_valid_a), 0);
        do_op(8'd7, 8'd9, 2'b10, 1'b0, 1'b0, 1'b0, r);
        chk("post_rst_op", r, 63);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: got %0d expected %0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
